branch_predictor: RTL and testbench

Fetch-stage dynamic branch predictor for the five-stage MIPS pipeline. It looks up each fetch PC in a direct-mapped branch target buffer (BTB) and a table of 2-bit saturating counters (PHT), and supplies a predicted next PC. It carries its own prediction into Decode, compares it with the Decode-stage branch resolution, and drives `predict_miss_o` to the hazard unit together with the recovery PC. Branch and misprediction counts are kept for performance measurement.

---
 rtl/branch_predictor_pkg.sv | 26 ++
 rtl/branch_target_buffer.sv | 57 +++++
 rtl/branch_predictor.sv | 126 ++++++++++++
 tb/tb_branch_predictor.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types, counter encodings and the saturating-counter helper
// used by the fetch-stage branch predictor.
package bp_pkg;

    typedef logic [1:0] counter_t;

    localparam counter_t SNT = 2'd0;
    localparam counter_t WNT = 2'd1;
    localparam counter_t WT  = 2'd2;
    localparam counter_t ST  = 2'd3;

    // Tag is held at full word width; bits above the real tag stay zero.
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] target;
    } btb_entry_t;

    function automatic counter_t sat_update(input counter_t c, input logic taken);
        if (taken)
            return (c == ST) ? ST : counter_t'(c + 2'd1);
        else
            return (c == SNT) ? SNT : counter_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: one combinational read port, one synchronous write
// port; only the valid bits are reset.
module branch_target_buffer
    import bp_pkg::*;
#(
    parameter int BTB_BITS = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_rd_pc,
    output logic        o_rd_hit,
    output logic [31:0] o_rd_target,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_pc,
    input  logic [31:0] i_wr_target
);

    localparam int DEPTH = 1 << BTB_BITS;

    logic [DEPTH-1:0]    r_valid;
    logic [31:0]         r_tag    [DEPTH];
    logic [31:0]         r_target [DEPTH];

    logic [BTB_BITS-1:0] w_rd_idx;
    logic [BTB_BITS-1:0] w_wr_idx;
    logic [31:0]         w_rd_tag;
    logic [31:0]         w_wr_tag;
    btb_entry_t          w_rd_entry;

    assign w_rd_idx = i_rd_pc[BTB_BITS+1:2];
    assign w_wr_idx = i_wr_pc[BTB_BITS+1:2];
    assign w_rd_tag = i_rd_pc >> (BTB_BITS + 2);
    assign w_wr_tag = i_wr_pc >> (BTB_BITS + 2);

    assign w_rd_entry.valid  = r_valid[w_rd_idx];
    assign w_rd_entry.tag    = r_tag[w_rd_idx];
    assign w_rd_entry.target = r_target[w_rd_idx];

    assign o_rd_hit    = w_rd_entry.valid && (w_rd_entry.tag == w_rd_tag);
    assign o_rd_target = w_rd_entry.target;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_valid <= '0;
        else if (i_wr_en)
            r_valid[w_wr_idx] <= 1'b1;
    end

    // Payload is qualified by valid, so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_tag[w_wr_idx]    <= w_wr_tag;
            r_target[w_wr_idx] <= i_wr_target;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage predictor: BTB + 2-bit PHT lookup, Decode-stage miss
// detection against resolved branches, and branch/miss counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int PHT_BITS = 6,
    parameter int BTB_BITS = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_f_i,
    output logic        predict_taken_f_o,
    output logic [31:0] predict_pc_f_o,
    input  logic        stall_d_i,
    input  logic        flush_d_i,
    input  logic [31:0] pc_d_i,
    input  logic        branch_d_i,
    input  logic        pc_src_d_i,
    input  logic [31:0] pc_branch_d_i,
    output logic        predict_miss_o,
    output logic [31:0] recover_pc_o,
    output logic [31:0] branch_count_o,
    output logic [31:0] miss_count_o
);

    localparam int PHT_DEPTH = 1 << PHT_BITS;

    counter_t [PHT_DEPTH-1:0] r_pht;

    logic                r_d_valid;
    logic                r_d_taken;
    logic [31:0]         r_d_target;
    logic [PHT_BITS-1:0] r_d_pht_idx;
    logic [31:0]         r_branch_count;
    logic [31:0]         r_miss_count;

    logic [PHT_BITS-1:0] w_f_pht_idx;
    logic                w_btb_hit;
    logic [31:0]         w_btb_target;
    logic                w_f_taken;
    logic                w_miss;
    logic                w_update;
    logic                w_btb_wr;
    logic [31:0]         w_recover;

    assign w_f_pht_idx = pc_f_i[PHT_BITS+1:2];

    branch_target_buffer #(
        .BTB_BITS (BTB_BITS)
    ) u_btb (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_rd_pc     (pc_f_i),
        .o_rd_hit    (w_btb_hit),
        .o_rd_target (w_btb_target),
        .i_wr_en     (w_btb_wr),
        .i_wr_pc     (pc_d_i),
        .i_wr_target (pc_branch_d_i)
    );

    assign w_f_taken         = w_btb_hit && r_pht[w_f_pht_idx][1];
    assign predict_taken_f_o = w_f_taken;
    assign predict_pc_f_o    = w_f_taken ? w_btb_target : 32'd0;

    // A taken prediction on a non-branch is also a miss.
    always_comb begin
        w_miss = 1'b0;
        if (r_d_valid) begin
            if (branch_d_i)
                w_miss = (r_d_taken != pc_src_d_i) ||
                         (r_d_taken && pc_src_d_i && (r_d_target != pc_branch_d_i));
            else
                w_miss = r_d_taken;
        end
    end

    assign w_recover      = (branch_d_i && pc_src_d_i) ? pc_branch_d_i : pc_d_i + 32'd4;
    assign predict_miss_o = w_miss;
    assign recover_pc_o   = w_miss ? w_recover : 32'd0;

    assign w_update = r_d_valid && branch_d_i && !stall_d_i;
    assign w_btb_wr = w_update && pc_src_d_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < PHT_DEPTH; i++)
                r_pht[i] <= WNT;
        end else if (w_update) begin
            r_pht[r_d_pht_idx] <= sat_update(r_pht[r_d_pht_idx], pc_src_d_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_d_valid   <= 1'b0;
            r_d_taken   <= 1'b0;
            r_d_target  <= '0;
            r_d_pht_idx <= '0;
        end else if (!stall_d_i) begin
            if (flush_d_i) begin
                r_d_valid <= 1'b0;
            end else begin
                r_d_valid   <= 1'b1;
                r_d_taken   <= w_f_taken;
                r_d_target  <= predict_pc_f_o;
                r_d_pht_idx <= w_f_pht_idx;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_branch_count <= '0;
            r_miss_count   <= '0;
        end else if (!stall_d_i) begin
            if (w_update)
                r_branch_count <= r_branch_count + 32'd1;
            if (w_miss)
                r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign branch_count_o = r_branch_count;
    assign miss_count_o   = r_miss_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized bench for branch_predictor against an array-based reference
// model of the predictor tables, Decode latch and counters.
module tb_branch_predictor;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_f_i;
    logic        predict_taken_f_o;
    logic [31:0] predict_pc_f_o;
    logic        stall_d_i;
    logic        flush_d_i;
    logic [31:0] pc_d_i;
    logic        branch_d_i;
    logic        pc_src_d_i;
    logic [31:0] pc_branch_d_i;
    logic        predict_miss_o;
    logic [31:0] recover_pc_o;
    logic [31:0] branch_count_o;
    logic [31:0] miss_count_o;

    branch_predictor #(.PHT_BITS(6), .BTB_BITS(4)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .pc_f_i            (pc_f_i),
        .predict_taken_f_o (predict_taken_f_o),
        .predict_pc_f_o    (predict_pc_f_o),
        .stall_d_i         (stall_d_i),
        .flush_d_i         (flush_d_i),
        .pc_d_i            (pc_d_i),
        .branch_d_i        (branch_d_i),
        .pc_src_d_i        (pc_src_d_i),
        .pc_branch_d_i     (pc_branch_d_i),
        .predict_miss_o    (predict_miss_o),
        .recover_pc_o      (recover_pc_o),
        .branch_count_o    (branch_count_o),
        .miss_count_o      (miss_count_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int          m_pht  [64];
    bit          m_bv   [16];
    logic [31:0] m_btag [16];
    logic [31:0] m_btgt [16];
    bit          m_dv, m_dt;
    logic [31:0] m_dtgt, m_dpc;
    int          m_dpi;
    logic [31:0] m_bc, m_mc;
    bit          e_pt, e_miss;
    logic [31:0] e_ppc, e_rec;

    logic [31:0] pcs  [8] = '{32'h40, 32'h44, 32'h48, 32'h80, 32'h1040, 32'h100, 32'h140, 32'h4c};
    logic [31:0] tgts [4] = '{32'h80, 32'hc0, 32'h100, 32'h40};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 64; i++) m_pht[i] = 1;
        for (int i = 0; i < 16; i++) begin
            m_bv[i] = 0; m_btag[i] = '0; m_btgt[i] = '0;
        end
        m_dv = 0; m_dt = 0; m_dtgt = '0; m_dpc = '0; m_dpi = 0;
        m_bc = '0; m_mc = '0;
    endfunction

    // Expected combinational outputs from current model state and inputs.
    task automatic eval_check();
        int  bi, pi;
        bit  hit;
        bi  = int'((pc_f_i >> 2) % 16);
        pi  = int'((pc_f_i >> 2) % 64);
        hit = m_bv[bi] && (m_btag[bi] == (pc_f_i >> 6));
        e_pt  = hit && (m_pht[pi] >= 2);
        e_ppc = e_pt ? m_btgt[bi] : 32'd0;
        if (!m_dv)           e_miss = 0;
        else if (branch_d_i) e_miss = (m_dt != pc_src_d_i) || (m_dt && pc_src_d_i && m_dtgt != pc_branch_d_i);
        else                 e_miss = m_dt;
        e_rec = !e_miss ? 32'd0 : (branch_d_i && pc_src_d_i) ? pc_branch_d_i : m_dpc + 32'd4;
        check("ptaken", predict_taken_f_o, e_pt);
        check("ppc",    predict_pc_f_o,    e_ppc);
        check("miss",   predict_miss_o,    e_miss);
        check("recover", recover_pc_o,     e_rec);
        check("bcount", branch_count_o,    m_bc);
        check("mcount", miss_count_o,      m_mc);
    endtask

    task automatic drive(input logic [31:0] pcf, input bit st, input bit fl,
                         input bit br, input bit src, input logic [31:0] tgt);
        @(negedge clk_i);
        pc_f_i = pcf; stall_d_i = st; flush_d_i = fl;
        branch_d_i = br; pc_src_d_i = src; pc_branch_d_i = tgt;
        pc_d_i = m_dpc;
        #1;
        eval_check();
    endtask

    task automatic clock_update();
        int p, b;
        @(posedge clk_i);
        if (!stall_d_i) begin
            if (m_dv && branch_d_i) begin
                p = m_pht[m_dpi];
                m_pht[m_dpi] = pc_src_d_i ? ((p == 3) ? 3 : p + 1) : ((p == 0) ? 0 : p - 1);
                if (pc_src_d_i) begin
                    b = int'((m_dpc >> 2) % 16);
                    m_bv[b] = 1; m_btag[b] = m_dpc >> 6; m_btgt[b] = pc_branch_d_i;
                end
                m_bc = m_bc + 1;
            end
            if (e_miss) m_mc = m_mc + 1;
            if (flush_d_i) m_dv = 0;
            else begin
                m_dv = 1; m_dt = e_pt; m_dtgt = e_ppc;
                m_dpi = int'((pc_f_i >> 2) % 64); m_dpc = pc_f_i;
            end
        end
    endtask

    task automatic step(input logic [31:0] pcf, input bit st, input bit fl,
                        input bit br, input bit src, input logic [31:0] tgt);
        drive(pcf, st, fl, br, src, tgt);
        clock_update();
    endtask

    initial begin
        rst_i = 1; pc_f_i = 32'h40; stall_d_i = 0; flush_d_i = 0; pc_d_i = 0;
        branch_d_i = 0; pc_src_d_i = 0; pc_branch_d_i = 0;
        m_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_ptaken", predict_taken_f_o, 1'b0);
        check("rst_ppc",    predict_pc_f_o,    32'd0);
        check("rst_miss",   predict_miss_o,    1'b0);
        check("rst_rec",    recover_pc_o,      32'd0);
        check("rst_bc",     branch_count_o,    32'd0);
        check("rst_mc",     miss_count_o,      32'd0);
        rst_i = 0;

        // First encounter: 0x40 taken to 0x80 mispredicts
        step(32'h40, 0, 0, 0, 0, 0);
        drive(32'h48, 0, 0, 1, 1, 32'h80);
        check("first_miss", predict_miss_o, 1'b1);
        check("first_rec",  recover_pc_o,   32'h80);
        clock_update();
        #1;
        check("first_bc", branch_count_o, 32'd1);
        check("first_mc", miss_count_o,   32'd1);

        // Learned, then a not-taken resolution
        drive(32'h40, 0, 0, 0, 0, 0);
        check("learn_pt",  predict_taken_f_o, 1'b1);
        check("learn_ppc", predict_pc_f_o,    32'h80);
        clock_update();
        step(32'h80, 0, 0, 1, 1, 32'h80);
        step(32'h40, 0, 0, 0, 0, 0);
        drive(32'h44, 0, 0, 1, 0, 32'h80);
        check("nt_rec", recover_pc_o, 32'h44);
        clock_update();

        // Miss held under stall, then released; then a flushed slot
        step(32'h40, 0, 0, 0, 0, 0);
        repeat (3) step(32'h48, 1, 0, 1, 0, 32'h80);
        step(32'h48, 0, 0, 1, 0, 32'h80);
        step(32'h40, 0, 1, 0, 0, 0);
        step(32'h44, 0, 0, 1, 1, 32'hc0);

        // Same-cycle update and lookup of PHT index 0x10
        step(32'h40, 0, 0, 0, 0, 0);
        step(32'h40, 0, 0, 1, 1, 32'h80);
        step(32'h40, 0, 0, 1, 1, 32'h80);
        step(32'h40, 0, 0, 1, 1, 32'h80);

        // Async reset while a miss is pending in D
        drive(32'h48, 0, 0, 1, 0, 32'h80);
        check("pre_rst_miss", predict_miss_o, 1'b1);
        #1 rst_i = 1;
        #1;
        check("arst_miss", predict_miss_o,    1'b0);
        check("arst_rec",  recover_pc_o,      32'd0);
        check("arst_bc",   branch_count_o,    32'd0);
        check("arst_mc",   miss_count_o,      32'd0);
        rst_i = 0;
        m_reset();
        pc_f_i = 32'h40;
        #1;
        check("arst_pt40", predict_taken_f_o, 1'b0);
        eval_check();
        clock_update();

        for (int n = 0; n < 1500; n++) begin
            step(pcs[$urandom_range(0, 7)],
                 ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 1),
                 ($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
                 tgts[$urandom_range(0, 3)]);
        end
        #1;
        check("final_bc", branch_count_o, m_bc);
        check("final_mc", miss_count_o,   m_mc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
